// File: rtl/ff_evt_pkg.sv
// Shared constants and state encoding for the ff_evt event accumulator.
// Optional IRQ feature: FF_EVT_IRQ_EN.
package ff_evt_pkg;

  localparam int CNT_W_DEF      = 8;
  localparam int WIN_LEN_DEF    = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/ff_evt_fifo.sv
// Result FIFO for ff_evt_acc: power-of-two depth, head data zero when empty.
// Push while full is accepted only if a pop happens in the same cycle.
module ff_evt_fifo
  import ff_evt_pkg::*;
#(
  parameter int W     = CNT_W_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic         ff_clk_B,
  input  logic         ff_rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = clog2_min1(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  // When full, the slot being popped is the one overwritten.
  assign wr_en = push & (~full | pop);
  assign rdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge ff_clk_B) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge ff_clk_B or negedge ff_rst_n) begin
    if (!ff_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ff_evt_acc.sv
// Windowed event counter feeding a result FIFO with sticky overflow flag.
// Define FF_EVT_IRQ_EN to add the thr input and irq threshold pulse.
module ff_evt_acc
  import ff_evt_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WIN_LEN    = WIN_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             ff_clk_B,
  input  logic             ff_rst_n,
  input  logic             evt_pulse,
  input  logic             en,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  input  logic             ovf_clr,
`ifdef FF_EVT_IRQ_EN
  input  logic [CNT_W-1:0] thr,
  output logic             irq,
`endif
  output logic             fifo_ovf
);

  localparam int TW = clog2_min1(WIN_LEN);
  localparam logic [TW-1:0] T_LAST = TW'(WIN_LEN - 1);

  state_t           state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] acc;
  logic [CNT_W-1:0] acc_inc;
  logic             push;
  logic             pop;
  logic             drop;
  logic             full;
  logic             empty;

  // Saturating increment; also the value pushed on window close.
  assign acc_inc = (evt_pulse && (acc != '1)) ? acc + 1'b1 : acc;
  assign push    = (state == RUN) & en & (timer == T_LAST);
  assign pop     = cnt_valid & cnt_ready;
  assign drop    = push & full & ~pop;
  assign cnt_valid = ~empty;

  always_ff @(posedge ff_clk_B or negedge ff_rst_n) begin
    if (!ff_rst_n) begin
      state <= IDLE;
      timer <= '0;
      acc   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          timer <= '0;
          acc   <= '0;
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            state <= IDLE;
            timer <= '0;
            acc   <= '0;
          end else if (timer == T_LAST) begin
            timer <= '0;
            acc   <= '0;
          end else begin
            timer <= timer + 1'b1;
            acc   <= acc_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge ff_clk_B or negedge ff_rst_n) begin
    if (!ff_rst_n)    fifo_ovf <= 1'b0;
    else if (drop)    fifo_ovf <= 1'b1;
    else if (ovf_clr) fifo_ovf <= 1'b0;
  end

`ifdef FF_EVT_IRQ_EN
  // Fires on every window close at or above thr, dropped or not.
  always_ff @(posedge ff_clk_B or negedge ff_rst_n) begin
    if (!ff_rst_n) irq <= 1'b0;
    else           irq <= push & (acc_inc >= thr);
  end
`endif

  ff_evt_fifo #(
    .W     (CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ff_clk_B (ff_clk_B),
    .ff_rst_n (ff_rst_n),
    .push     (push),
    .pop      (cnt_ready),
    .wdata    (acc_inc),
    .rdata    (cnt_data),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_ff_evt_acc.sv
// Directed bench for ff_evt_acc: default instance plus a WIN_LEN=300 one.
// Build with FF_EVT_IRQ_EN to also exercise thr/irq.
module tb_ff_evt_acc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0;
  logic       evt = 1'b0;
  logic       ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ovf;

  logic       en_s = 1'b0;
  logic       evt_s = 1'b0;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ovf;

`ifdef FF_EVT_IRQ_EN
  logic [7:0] thr = 8'd3;
  logic       irq;
  logic       s_irq;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ff_evt_acc u_dut (
    .ff_clk_B  (clk),
    .ff_rst_n  (rst_n),
    .evt_pulse (evt),
    .en        (en),
    .cnt_data  (data),
    .cnt_valid (valid),
    .cnt_ready (ready),
    .ovf_clr   (ovf_clr),
`ifdef FF_EVT_IRQ_EN
    .thr       (thr),
    .irq       (irq),
`endif
    .fifo_ovf  (ovf)
  );

  ff_evt_acc #(.CNT_W(8), .WIN_LEN(300), .FIFO_DEPTH(4)) u_sat (
    .ff_clk_B  (clk),
    .ff_rst_n  (rst_n),
    .evt_pulse (evt_s),
    .en        (en_s),
    .cnt_data  (s_data),
    .cnt_valid (s_valid),
    .cnt_ready (1'b1),
    .ovf_clr   (1'b0),
`ifdef FF_EVT_IRQ_EN
    .thr       (thr),
    .irq       (s_irq),
`endif
    .fifo_ovf  (s_ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic window(input int n);
    for (int i = 0; i < 16; i++) begin
      evt = (i < n);
      step();
    end
    evt = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2;
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_s_valid", s_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();
    chk("idle_valid", valid, 0);

    // saturation over a 300-cycle window
    en_s = 1'b1;
    step();
    evt_s = 1'b1;
    repeat (299) step();
    chk("sat_pre_valid", s_valid, 0);
    step();
    evt_s = 1'b0;
    chk("sat_valid", s_valid, 1);
    chk("sat_data", s_data, 255);
`ifdef FF_EVT_IRQ_EN
    chk("sat_irq", s_irq, 1);
`endif
    en_s = 1'b0;
    step();
    chk("sat_pop", s_valid, 0);
    chk("sat_ovf", s_ovf, 0);

    // first window, 5 pulses incl. closing cycle
    ready = 1'b1;
    en = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      evt = (i == 0 || i == 3 || i == 7 || i == 11);
      step();
    end
    evt = 1'b0;
    chk("w1_pre_valid", valid, 0);
    evt = 1'b1;
    step();
    evt = 1'b0;
    chk("w1_valid", valid, 1);
    chk("w1_data", data, 5);
    step();
    chk("w1_popped", valid, 0);
    en = 1'b0;
    step();

    // five windows with no consumer: overflow
    ready = 1'b0;
    en = 1'b1;
    step();
    for (int w = 1; w <= 5; w++) begin
      window(w);
      chk("ovf_head", data, 1);
      chk("ovf_flag", ovf, (w == 5));
    end
    en = 1'b0;
    step();
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);
    ready = 1'b1;
    for (int w = 1; w <= 4; w++) begin
      chk("drain_valid", valid, 1);
      chk("drain_data", data, w);
      step();
    end
    chk("drain_empty", valid, 0);

    // full FIFO, push and pop together
    ready = 1'b0;
    en = 1'b1;
    step();
    for (int w = 1; w <= 4; w++) window(w);
    chk("full_head", data, 1);
    for (int i = 0; i < 15; i++) begin
      evt = (i < 5);
      step();
    end
    evt = 1'b0;
    ready = 1'b1;
    step();
    chk("pp_ovf", ovf, 0);
    chk("pp_valid", valid, 1);
    en = 1'b0;
    for (int w = 2; w <= 5; w++) begin
      chk("pp_data", data, w);
      step();
    end
    chk("pp_empty", valid, 0);

    // en dropped mid-window discards partial count
    ready = 1'b1;
    en = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      evt = (i < 3);
      step();
    end
    evt = 1'b0;
    en = 1'b0;
    step();
    chk("abort_valid", valid, 0);
    step();
    en = 1'b1;
    step();
    for (int i = 0; i < 15; i++) begin
      evt = (i < 2);
      step();
    end
    evt = 1'b0;
    chk("restart_pre", valid, 0);
    step();
    chk("restart_valid", valid, 1);
    chk("restart_data", data, 2);
    en = 1'b0;
    step();
    chk("restart_pop", valid, 0);

    // async reset with entries queued
    ready = 1'b0;
    en = 1'b1;
    step();
    window(3);
    window(6);
    for (int i = 0; i < 5; i++) begin
      evt = 1'b1;
      step();
    end
    evt = 1'b0;
    chk("pre_rst_data", data, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_data", data, 0);
    chk("arst_ovf", ovf, 0);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_valid", valid, 0);
    ready = 1'b1;
    en = 1'b1;
    step();
    window(3);
    chk("post_rst_w_valid", valid, 1);
    chk("post_rst_w_data", data, 3);
`ifdef FF_EVT_IRQ_EN
    chk("irq_hi", irq, 1);
`endif
    en = 1'b0;
    step();
    chk("post_rst_pop", valid, 0);
`ifdef FF_EVT_IRQ_EN
    chk("irq_lo", irq, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ff_evt_acc.md
FF_EVT_ACC -- requirements
Module: ff_evt_acc

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the per-window event count.
REQ-002 SHALL have parameter WIN_LEN, default 16: window length in ff_clk_B cycles, legal range 2..65535.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries, power of two, at least 2.
REQ-004 SHALL have port ff_clk_B  in  1  sole clock; all logic is rising-edge.
REQ-005 SHALL have port ff_rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port evt_pulse  in  1  single-cycle event strobe from the upstream synchroniser/edge detector, already in the ff_clk_B domain.
REQ-007 SHALL have port en  in  1  counting enable.
REQ-008 SHALL have port cnt_data  out  CNT_W  count at the head of the FIFO.
REQ-009 SHALL have port cnt_valid  out  1  FIFO non-empty.
REQ-010 SHALL have port cnt_ready  in  1  consumer accepts cnt_data.
REQ-011 SHALL have port ovf_clr  in  1  clears fifo_ovf.
REQ-012 SHALL have port fifo_ovf  out  1  sticky flag: a window result was dropped.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and RUN.
  - IDLE->RUN when en=1.
  - RUN->IDLE when en=0; the partial window is discarded, with timer and accumulator cleared.
REQ-014 SHALL advance the window timer in RUN from 0 to WIN_LEN-1 and wrap to 0; in IDLE the timer holds at 0.
REQ-015 SHALL increment the accumulator by 1 in each RUN cycle with evt_pulse=1, saturating at 2^CNT_W-1.
REQ-016 SHALL close the window in the RUN cycle where the timer equals WIN_LEN-1, and push that window's count into the FIFO.
  - The pushed count includes any evt_pulse in the closing cycle.
  - The accumulator restarts at 0 on the next cycle.
REQ-017 SHALL drive cnt_valid = FIFO not empty, with cnt_data the oldest entry.
  - A pop occurs on cnt_valid & cnt_ready.
  - cnt_data is held stable while cnt_valid=1 and cnt_ready=0.
REQ-018 SHALL give a push exactly one cycle of latency: cnt_valid asserts the cycle after the window-close cycle when the FIFO was empty.
REQ-019 SHALL handle a push with the FIFO full and no pop that cycle as follows:
  - drop the count;
  - leave the FIFO unchanged;
  - set fifo_ovf=1 on the next cycle.
REQ-020 SHALL accept a simultaneous push and pop when full without loss; fifo_ovf is not set.
REQ-021 SHALL hold fifo_ovf until ovf_clr=1; if ovf_clr and a new drop occur in the same cycle, fifo_ovf stays 1.
REQ-022 SHALL drain the FIFO normally while en=0.

Reset
REQ-023 SHALL, on ff_rst_n=0 at any time including mid-window or mid-handshake:
  - force FSM=IDLE, timer=0, accumulator=0, FIFO empty;
  - drive cnt_valid=0, cnt_data=0, fifo_ovf=0.
REQ-024 SHALL release reset with no output activity until en=1.

Configuration
REQ-025 SHALL, with macro FF_EVT_IRQ_EN defined, add these ports:
  - thr  in  CNT_W  threshold;
  - irq  out  1  one-cycle pulse, the cycle after a push whose count >= thr.
  - irq is also raised for a dropped push, and resets to 0.
REQ-026 SHALL, without FF_EVT_IRQ_EN, omit the thr and irq ports and all of their logic; all other behaviour is identical.

Structure
REQ-027 SHALL place the default CNT_W/WIN_LEN/FIFO_DEPTH constants and the IDLE/RUN state encoding in shared package ff_evt_pkg.
REQ-028 SHALL implement the FIFO as sub-module ff_evt_fifo (push, pop, full, empty, head data, asynchronous active-low reset).

Verification
REQ-029 SHALL cover: reset release, en=1, 5 pulses in the first window, cnt_ready=1 -> cnt_data=5 with cnt_valid high for 1 cycle starting at cycle 17 after en.
REQ-030 SHALL cover: evt_pulse held 1 for 300 cycles with CNT_W=8, WIN_LEN=300 -> count 255 (saturated).
REQ-031 SHALL cover: cnt_ready=0 across 5 windows with FIFO_DEPTH=4 -> 4 entries held, fifo_ovf=1 after window 5; then ovf_clr -> fifo_ovf=0; then draining returns windows 1-4 in order.
REQ-032 SHALL cover: FIFO full while the window closes with cnt_ready=1 in the same cycle -> no drop, fifo_ovf stays 0, newest count becomes the tail.
REQ-033 SHALL cover: en dropped at timer=7 with 3 pulses counted -> no push; after en is re-raised, the next window starts at timer 0 with count 0.
REQ-034 SHALL cover: ff_rst_n asserted mid-window with 2 entries queued -> cnt_valid=0, cnt_data=0, fifo_ovf=0 immediately, asynchronously; with FF_EVT_IRQ_EN and thr=3, a window of 3 pulses -> irq pulses 1 cycle.
